// File: rtl/tron_pkg.sv
// Tron arena engine shared types.
// Directions, colours, FSM states and small helpers.
package tron_pkg;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_UP    = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_SPAWN,
    ST_RUN,
    ST_EVAL,
    ST_COMMIT,
    ST_CHECK,
    ST_OVER
  } state_t;

  localparam logic [2:0] COLOUR_WALL = 3'b111;
  localparam logic [2:0] COLOUR_BG   = 3'b000;

  // Opposite directions differ only in the msb.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a ^ b) == 2'b10;
  endfunction

  function automatic logic [2:0] player_colour(input int i);
    return 3'(i + 1);
  endfunction

  function automatic dir_t spawn_dir(input int i);
    return (i % 2 == 1) ? DIR_LEFT : DIR_RIGHT;
  endfunction

endpackage

// File: rtl/tron_occupancy_ram.sv
// Arena occupancy bitmap, one bit per cell.
// Synchronous read with one-cycle latency, single write port.
module tron_occupancy_ram #(
  parameter int DEPTH = 19200,
  parameter int A_W   = 15
) (
  input  logic           clk_out_fast,
  input  logic           i_we,
  input  logic [A_W-1:0] i_addr,
  input  logic           i_wd,
  output logic           o_rd
);

  logic r_mem [DEPTH];

  always_ff @(posedge clk_out_fast) begin
    if (i_we) r_mem[i_addr] <= i_wd;
    o_rd <= r_mem[i_addr];
  end

endmodule

// File: rtl/tron_arena_engine.sv
// N-player Tron engine: moves players, detects deaths,
// and serialises every pixel write onto one vga port.
module tron_arena_engine
  import tron_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int ARENA_W     = 160,
  parameter int ARENA_H     = 120,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  localparam int WIN_W =
    (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                     clk_out_fast,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     tick,
  input  logic [2*NUM_PLAYERS-1:0] dir_req,
  input  logic [NUM_PLAYERS-1:0]   dir_valid,
  output logic                     plot,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic [2:0]               colour,
  output logic [NUM_PLAYERS-1:0]   alive,
  output logic                     game_over,
  output logic [WIN_W-1:0]         winner,
  output logic                     winner_valid
);

  localparam int A_W = $clog2(ARENA_W * ARENA_H);
  localparam int SPC = ARENA_W / (NUM_PLAYERS + 1);
  localparam logic [Y_W-1:0] SPAWN_Y = Y_W'(ARENA_H / 2);

  state_t r_state, w_next;

  logic [X_W-1:0]         r_cx;
  logic [Y_W-1:0]         r_cy;
  logic [WIN_W-1:0]       r_idx;
  logic                   r_ph;
  logic [NUM_PLAYERS-1:0] r_die;
  logic [NUM_PLAYERS-1:0] r_alive;
  dir_t                   r_dir  [NUM_PLAYERS];
  dir_t                   r_pend [NUM_PLAYERS];
  logic [X_W-1:0]         r_hx   [NUM_PLAYERS];
  logic [Y_W-1:0]         r_hy   [NUM_PLAYERS];

  logic [X_W-1:0]         w_nx [NUM_PLAYERS];
  logic [Y_W-1:0]         w_ny [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] w_hit;
  logic [X_W-1:0]         w_ax;
  logic [Y_W-1:0]         w_ay;
  logic [A_W-1:0]         w_addr;
  logic                   w_we, w_wd, w_rd;
  logic                   w_wall, w_last_cell;
  logic                   w_last_idx, w_move;
  logic [3:0]             w_cnt;
  logic [WIN_W-1:0]       w_win;

  assign alive      = r_alive;
  assign w_last_idx = (r_idx == WIN_W'(NUM_PLAYERS - 1));
  assign w_move     = r_alive[r_idx] && !r_die[r_idx];
  assign w_wall     = (r_cx == '0) || (r_cy == '0) ||
                      (r_cx == X_W'(ARENA_W - 1)) ||
                      (r_cy == Y_W'(ARENA_H - 1));
  assign w_last_cell = (r_cx == X_W'(ARENA_W - 1)) &&
                       (r_cy == Y_W'(ARENA_H - 1));

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      w_nx[i] = r_hx[i];
      w_ny[i] = r_hy[i];
      unique case (r_dir[i])
        DIR_DOWN:  w_ny[i] = r_hy[i] + Y_W'(1);
        DIR_RIGHT: w_nx[i] = r_hx[i] + X_W'(1);
        DIR_UP:    w_ny[i] = r_hy[i] - Y_W'(1);
        DIR_LEFT:  w_nx[i] = r_hx[i] - X_W'(1);
        default:   ;
      endcase
    end
  end

  // Head-on: two live players aiming at the same cell.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      for (int j = 0; j < NUM_PLAYERS; j++)
        if (j != i && r_alive[j] &&
            w_nx[i] == w_nx[j] && w_ny[i] == w_ny[j])
          w_hit[i] = 1'b1;
  end

  always_comb begin
    w_cnt = '0;
    w_win = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      w_cnt = w_cnt + 4'(r_alive[i]);
      if (r_alive[i]) w_win = WIN_W'(i);
    end
  end

  always_comb begin
    w_ax = r_cx;
    w_ay = r_cy;
    w_we = 1'b0;
    w_wd = 1'b1;
    unique case (r_state)
      ST_CLEAR: begin
        w_we = 1'b1;
        w_wd = w_wall;
      end
      ST_SPAWN: begin
        w_ax = X_W'((int'(r_idx) + 1) * SPC);
        w_ay = SPAWN_Y;
        w_we = 1'b1;
      end
      ST_EVAL, ST_COMMIT: begin
        w_ax = w_nx[r_idx];
        w_ay = w_ny[r_idx];
        w_we = (r_state == ST_COMMIT) && w_move;
      end
      default: ;
    endcase
  end

  assign w_addr = A_W'(w_ay) * A_W'(ARENA_W) + A_W'(w_ax);

  tron_occupancy_ram #(
    .DEPTH (ARENA_W * ARENA_H),
    .A_W   (A_W)
  ) u_occ (
    .clk_out_fast (clk_out_fast),
    .i_we         (w_we),
    .i_addr       (w_addr),
    .i_wd         (w_wd),
    .o_rd         (w_rd)
  );

  always_ff @(posedge clk_out_fast) begin
    if (!resetn) r_state <= ST_CLEAR;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_CLEAR:  if (w_last_cell) w_next = ST_IDLE;
      ST_IDLE:   if (start) w_next = ST_SPAWN;
      ST_SPAWN:  if (w_last_idx) w_next = ST_RUN;
      ST_RUN:    if (tick) w_next = ST_EVAL;
      ST_EVAL:   if (w_last_idx && r_ph) w_next = ST_COMMIT;
      ST_COMMIT: if (w_last_idx) w_next = ST_CHECK;
      ST_CHECK:  w_next = (w_cnt <= 4'd1) ? ST_OVER : ST_RUN;
      ST_OVER:   if (start) w_next = ST_CLEAR;
      default:   w_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk_out_fast) begin
    if (!resetn) begin
      r_cx         <= '0;
      r_cy         <= '0;
      r_idx        <= '0;
      r_ph         <= 1'b0;
      r_die        <= '0;
      r_alive      <= '0;
      plot         <= 1'b0;
      x            <= '0;
      y            <= '0;
      colour       <= '0;
      game_over    <= 1'b0;
      winner       <= '0;
      winner_valid <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_dir[i]  <= spawn_dir(i);
        r_pend[i] <= spawn_dir(i);
        r_hx[i]   <= '0;
        r_hy[i]   <= '0;
      end
    end else begin
      plot <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++)
        if (dir_valid[i] &&
            !is_reverse(dir_t'(dir_req[2*i +: 2]), r_dir[i]))
          r_pend[i] <= dir_t'(dir_req[2*i +: 2]);
      unique case (r_state)
        ST_CLEAR: begin
          plot   <= 1'b1;
          x      <= r_cx;
          y      <= r_cy;
          colour <= w_wall ? COLOUR_WALL : COLOUR_BG;
          if (r_cx == X_W'(ARENA_W - 1)) begin
            r_cx <= '0;
            r_cy <= w_last_cell ? '0 : r_cy + Y_W'(1);
          end else begin
            r_cx <= r_cx + X_W'(1);
          end
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            r_dir[i]  <= spawn_dir(i);
            r_pend[i] <= spawn_dir(i);
          end
        end
        ST_SPAWN: begin
          plot          <= 1'b1;
          x             <= w_ax;
          y             <= w_ay;
          colour        <= player_colour(int'(r_idx));
          r_hx[r_idx]   <= w_ax;
          r_hy[r_idx]   <= w_ay;
          r_dir[r_idx]  <= r_pend[r_idx];
          r_idx         <= w_last_idx ? '0 : r_idx + WIN_W'(1);
          if (w_last_idx) r_alive <= '1;
        end
        ST_RUN: begin
          r_idx <= '0;
          r_ph  <= 1'b0;
          if (tick)
            for (int i = 0; i < NUM_PLAYERS; i++)
              r_dir[i] <= r_pend[i];
        end
        ST_EVAL: begin
          r_ph <= !r_ph;
          if (r_ph) begin
            r_die[r_idx] <= !r_alive[r_idx] || w_rd || w_hit[r_idx];
            r_idx <= w_last_idx ? '0 : r_idx + WIN_W'(1);
          end
        end
        ST_COMMIT: begin
          if (w_move) begin
            r_hx[r_idx] <= w_nx[r_idx];
            r_hy[r_idx] <= w_ny[r_idx];
            plot        <= 1'b1;
            x           <= w_nx[r_idx];
            y           <= w_ny[r_idx];
            colour      <= player_colour(int'(r_idx));
          end else begin
            r_alive[r_idx] <= 1'b0;
          end
          r_idx <= w_last_idx ? '0 : r_idx + WIN_W'(1);
        end
        ST_CHECK: begin
          if (w_cnt <= 4'd1) begin
            game_over    <= 1'b1;
            winner_valid <= (w_cnt == 4'd1);
            winner       <= (w_cnt == 4'd1) ? w_win : '0;
          end
        end
        ST_OVER: begin
          if (start) begin
            r_alive      <= '0;
            game_over    <= 1'b0;
            winner       <= '0;
            winner_valid <= 1'b0;
            r_cx         <= '0;
            r_cy         <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tron_arena_engine.sv
// Self-checking bench for tron_arena_engine.
// Compares the DUT against a cell-level game model.
module tb_tron_arena_engine;

  localparam int NP = 2;
  localparam int AW = 160;
  localparam int AH = 120;

  logic          clk_out_fast = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          tick = 1'b0;
  logic [2*NP-1:0] dir_req = '0;
  logic [NP-1:0] dir_valid = '0;
  logic          plot;
  logic [7:0]    x;
  logic [6:0]    y;
  logic [2:0]    colour;
  logic [NP-1:0] alive;
  logic          game_over;
  logic [0:0]    winner;
  logic          winner_valid;

  int n_chk = 0;
  int n_fail = 0;

  int mx [NP];
  int my [NP];
  int md [NP];
  int mp [NP];
  bit ma [NP];
  bit mocc [AW][AH];
  bit mover;
  bit mwv;
  int mwin;
  bit mv_e [NP];
  int ex_e [NP];
  int ey_e [NP];
  int obs_x [NP];

  tron_arena_engine dut (
    .clk_out_fast (clk_out_fast),
    .resetn       (resetn),
    .start        (start),
    .tick         (tick),
    .dir_req      (dir_req),
    .dir_valid    (dir_valid),
    .plot         (plot),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .alive        (alive),
    .game_over    (game_over),
    .winner       (winner),
    .winner_valid (winner_valid)
  );

  always #5 clk_out_fast = ~clk_out_fast;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_out_fast);
    #1;
  endtask

  function automatic int dxf(input int d);
    case (d)
      1: return 1;
      3: return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int dyf(input int d);
    case (d)
      0: return 1;
      2: return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int abits();
    int r = 0;
    for (int i = 0; i < NP; i++) if (ma[i]) r += (1 << i);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < AW; i++)
      for (int j = 0; j < AH; j++)
        mocc[i][j] = (i == 0 || j == 0 || i == AW-1 || j == AH-1);
    for (int i = 0; i < NP; i++) begin
      ma[i] = 0;
      md[i] = (i % 2 == 1) ? 3 : 1;
      mp[i] = md[i];
    end
    mover = 0;
    mwv = 0;
    mwin = 0;
  endtask

  task automatic model_tick();
    int nx [NP];
    int ny [NP];
    bit die [NP];
    int cnt;
    for (int i = 0; i < NP; i++) begin
      md[i] = mp[i];
      nx[i] = mx[i] + dxf(md[i]);
      ny[i] = my[i] + dyf(md[i]);
    end
    for (int i = 0; i < NP; i++) begin
      die[i] = 0;
      if (ma[i]) begin
        if (nx[i] <= 0 || ny[i] <= 0 || nx[i] >= AW-1 ||
            ny[i] >= AH-1 || mocc[nx[i]][ny[i]])
          die[i] = 1;
        for (int j = 0; j < NP; j++)
          if (j != i && ma[j] && nx[i] == nx[j] && ny[i] == ny[j])
            die[i] = 1;
      end
    end
    cnt = 0;
    for (int i = 0; i < NP; i++) begin
      mv_e[i] = ma[i] && !die[i];
      if (mv_e[i]) begin
        mx[i] = nx[i];
        my[i] = ny[i];
        mocc[nx[i]][ny[i]] = 1;
        ex_e[i] = nx[i];
        ey_e[i] = ny[i];
        cnt++;
        mwin = i;
      end else begin
        ma[i] = 0;
      end
    end
    if (cnt <= 1) begin
      mover = 1;
      mwv = (cnt == 1);
      if (cnt == 0) mwin = 0;
    end
  endtask

  task automatic req(input logic [NP-1:0] v, input logic [2*NP-1:0] d);
    int nd;
    dir_valid = v;
    dir_req = d;
    cyc();
    dir_valid = '0;
    for (int i = 0; i < NP; i++)
      if (v[i]) begin
        nd = int'(d[2*i +: 2]);
        if (!(dxf(nd) == -dxf(md[i]) && dyf(nd) == -dyf(md[i])))
          mp[i] = nd;
      end
  endtask

  task automatic do_clear();
    int n = 0, bad = 0, c00 = -1, cend = -1, cmid = -1;
    int ex, ey, ec;
    model_reset();
    for (int t = 0; t < AW*AH + 10 && n < AW*AH; t++) begin
      cyc();
      if (plot) begin
        ex = n % AW;
        ey = n / AW;
        ec = (ex == 0 || ey == 0 || ex == AW-1 || ey == AH-1) ? 7 : 0;
        if (int'(x) != ex || int'(y) != ey || int'(colour) != ec) bad++;
        if (x == 0 && y == 0) c00 = int'(colour);
        if (x == 159 && y == 119) cend = int'(colour);
        if (x == 80 && y == 60) cmid = int'(colour);
        n++;
      end
    end
    check("clr_count", n, AW*AH);
    check("clr_bad_pixels", bad, 0);
    check("clr_c_0_0", c00, 7);
    check("clr_c_159_119", cend, 7);
    check("clr_c_80_60", cmid, 0);
    cyc();
    check("clr_idle_plot", int'(plot), 0);
    check("clr_idle_over", int'(game_over), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < NP; i++) begin
      md[i] = mp[i];
      mx[i] = (i + 1) * (AW / (NP + 1));
      my[i] = AH / 2;
      mocc[mx[i]][my[i]] = 1;
      ma[i] = 1;
    end
    for (int k = 1; k <= NP + 1; k++) begin
      cyc();
      if (k <= NP) begin
        check("spawn_plot", int'(plot), 1);
        check("spawn_x", int'(x), mx[k-1]);
        check("spawn_y", int'(y), my[k-1]);
        check("spawn_colour", int'(colour), k);
      end else begin
        check("spawn_end_plot", int'(plot), 0);
      end
    end
    check("spawn_alive", int'(alive), abits());
  endtask

  task automatic do_tick();
    bit e;
    for (int i = 0; i < NP; i++) obs_x[i] = -1;
    model_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    for (int k = 1; k <= 2*NP + 1 + NP; k++) begin
      cyc();
      e = 0;
      if (k >= 2*NP + 1 && k < 3*NP + 1) e = mv_e[k - 2*NP - 1];
      check("tick_plot", int'(plot), int'(e));
      if (e && plot) begin
        obs_x[k - 2*NP - 1] = int'(x);
        check("tick_x", int'(x), ex_e[k - 2*NP - 1]);
        check("tick_y", int'(y), ey_e[k - 2*NP - 1]);
        check("tick_colour", int'(colour), k - 2*NP);
      end
    end
    check("tick_alive", int'(alive), abits());
    check("tick_over", int'(game_over), int'(mover));
    if (mover) begin
      check("tick_wvalid", int'(winner_valid), int'(mwv));
      check("tick_winner", int'(winner), mwin);
    end
  endtask

  initial begin
    int n;
    // Reset state and full arena clear
    cyc();
    check("rst_plot", int'(plot), 0);
    check("rst_xy", int'(x) + int'(y), 0);
    check("rst_colour", int'(colour), 0);
    check("rst_alive", int'(alive), 0);
    check("rst_over", int'(game_over), 0);
    check("rst_winner", int'(winner) + int'(winner_valid), 0);
    resetn = 1'b1;
    do_clear();

    // Spawn, first moves, ignored reverse request
    do_start();
    check("t2_alive", int'(alive), 3);
    do_tick();
    check("t3_p0x", obs_x[0], 54);
    check("t3_p1x", obs_x[1], 105);
    req(2'b01, 4'b0011);
    do_tick();
    check("t4_p0x", obs_x[0], 55);

    // Random steering until the round ends
    for (int t = 0; t < 150 && !mover; t++) begin
      if ($urandom_range(0, 1) == 1)
        req(NP'($urandom_range(0, 3)), (2*NP)'($urandom_range(0, 15)));
      do_tick();
    end
    if (mover) begin
      start = 1'b1;
      cyc();
      start = 1'b0;
    end else begin
      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
    end
    do_clear();

    // Tick outside RUN is dropped, then head-on draw
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (plot) n++;
    end
    check("idle_tick_drop", n, 0);
    do_start();
    for (int t = 0; t < 27; t++) do_tick();
    check("t5_alive", int'(alive), 0);
    check("t5_over", int'(game_over), 1);
    check("t5_wvalid", int'(winner_valid), 0);

    // P0 up, P1 down: P1 hits the bottom wall
    start = 1'b1;
    cyc();
    start = 1'b0;
    do_clear();
    req(2'b11, 4'b0010);
    do_start();
    for (int t = 0; t < 59; t++) do_tick();
    check("t6_alive", int'(alive), 1);
    check("t6_over", int'(game_over), 1);
    check("t6_winner", int'(winner), 0);
    check("t6_wvalid", int'(winner_valid), 1);

    // Reset in the middle of EVAL
    start = 1'b1;
    cyc();
    start = 1'b0;
    do_clear();
    do_start();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    cyc();
    resetn = 1'b0;
    cyc();
    check("t7_plot_rst", int'(plot), 0);
    check("t7_alive_rst", int'(alive), 0);
    resetn = 1'b1;
    cyc();
    check("t7_plot", int'(plot), 1);
    check("t7_xy", int'(x) * 1000 + int'(y), 0);
    cyc();
    check("t7_x1", int'(x), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
